// File: rtl/cpu4_ram_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between instruction
// fetch (port 0) and load/store (port 1). At most one access goes to the RAM
// per clock. A {valid, owner} pipeline that matches the RAM read latency
// sends each read response back to the port that issued it.
module cpu4_ram_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 1   // 1..4 clocks from accepting edge to ram_q
) (
  input  logic          clk,
  input  logic          resetn,
  // requester 0: instruction fetch
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  // requester 1: load/store
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  // RAM side
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wen,
  input  logic [DW-1:0] ram_q
);

  // Index of the port that won the most recent accepted access.
  // Resetting it to 1 lets port 0 win the first conflict.
  logic last_gnt_q, last_gnt_d;

  // Read-return pipeline: stage 0 loads on the accepting edge, and the last
  // stage lines up with the clock in which ram_q holds the data.
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] own_q, own_d;

  logic accept;
  logic sel;
  logic rd_accept;

  // Grant decision: a single requester always wins. A conflict goes to the
  // port that did not win last. Reset masks every grant.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave a value
    // unassigned. An unassigned path would infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (resetn) begin
      if (req0 && req1) begin
        gnt0 = last_gnt_q;
        gnt1 = ~last_gnt_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign accept    = gnt0 | gnt1;
  assign sel       = gnt1;
  assign rd_accept = (gnt0 & ~we0) | (gnt1 & ~we1);

  // RAM drive: route the granted port's command. Drive all zeros when idle.
  always_comb begin
    ram_wen     = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    if (gnt0) begin
      ram_wen     = we0;
      ram_address = addr0;
      ram_data    = wdata0;
    end else if (gnt1) begin
      ram_wen     = we1;
      ram_address = addr1;
      ram_data    = wdata1;
    end
  end

  // Next state: last winner and the shifted read-return pipeline.
  always_comb begin
    last_gnt_d = accept ? sel : last_gnt_q;
    vld_d      = '0;
    own_d      = '0;
    vld_d[0]   = rd_accept;
    own_d[0]   = sel;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  // Control state: the reset clears in-flight reads and the arbitration history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_gnt_q <= 1'b1;
      vld_q      <= '0;
    end else begin
      // NOTE: use non-blocking assignments so every register samples its
      // pre-edge value, whatever order the statements appear in.
      last_gnt_q <= last_gnt_d;
      vld_q      <= vld_d;
    end
  end

  // Owner bits: meaningful only next to a set valid bit.
  always_ff @(posedge clk) begin
    // NOTE: payload bits that travel with a valid flag need no reset.
    // Clearing the valid bits is enough to discard them.
    own_q <= own_d;
  end

  // Response routing: ram_q fans out to both ports, and rvalid picks the owner.
  assign rvalid0 = resetn & vld_q[RD_LATENCY-1] & ~own_q[RD_LATENCY-1];
  assign rvalid1 = resetn & vld_q[RD_LATENCY-1] &  own_q[RD_LATENCY-1];
  assign rdata0  = ram_q;
  assign rdata1  = ram_q;

endmodule

// File: tb/tb_cpu4_ram_arbiter.sv
// Bench for cpu4_ram_arbiter. Three instances (RD_LATENCY = 1, 2, 3) share
// the same stimulus, and each has its own RAM model. Accepted reads push
// {cycle, port, data} onto a scoreboard. A negedge monitor expects each
// response exactly RD_LATENCY cycles later on every instance.
module tb_cpu4_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic [N-1:0]  gnt0_w, gnt1_w, rvalid0_w, rvalid1_w, ram_wen_w;
  logic [AW-1:0] ram_addr_w [N];
  logic [DW-1:0] ram_data_w [N];
  logic [DW-1:0] ram_q_w    [N];
  logic [DW-1:0] rdata0_w   [N];
  logic [DW-1:0] rdata1_w   [N];

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  for (genvar k = 0; k < N; k++) begin : g_dut
    cpu4_ram_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(k + 1)) u_dut (
      .clk        (clk),
      .resetn     (resetn),
      .req0       (req0),
      .we0        (we0),
      .addr0      (addr0),
      .wdata0     (wdata0),
      .gnt0       (gnt0_w[k]),
      .rvalid0    (rvalid0_w[k]),
      .rdata0     (rdata0_w[k]),
      .req1       (req1),
      .we1        (we1),
      .addr1      (addr1),
      .wdata1     (wdata1),
      .gnt1       (gnt1_w[k]),
      .rvalid1    (rvalid1_w[k]),
      .rdata1     (rdata1_w[k]),
      .ram_address(ram_addr_w[k]),
      .ram_data   (ram_data_w[k]),
      .ram_wen    (ram_wen_w[k]),
      .ram_q      (ram_q_w[k])
    );

    // RAM model: synchronous write-first, read data appears k+1 edges later.
    logic [DW-1:0] mem  [256];
    logic [DW-1:0] pipe [k+1];
    initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    always @(posedge clk) begin
      if (ram_wen_w[k]) mem[ram_addr_w[k]] <= ram_data_w[k];
      pipe[0] <= ram_wen_w[k] ? ram_data_w[k] : mem[ram_addr_w[k]];
      for (int i = 1; i <= k; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_q_w[k] = pipe[k];
  end

  // Reference state
  logic          m_last;
  logic [DW-1:0] m_mem [256];
  typedef struct {
    int            acc;
    logic          port;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: on instance k a read accepted in cycle a must show
  // rvalid in cycle a+k+1 only, carrying the data from the scoreboard.
  always @(negedge clk) begin : mon
    logic ev, ep, e0, e1;
    logic [DW-1:0] ed;
    for (int k = 0; k < N; k++) begin
      ev = 1'b0; ep = 1'b0; ed = '0;
      foreach (sb[j]) if (sb[j].acc == cyc - (k + 1)) begin
        ev = 1'b1; ep = sb[j].port; ed = sb[j].data;
      end
      e0 = ev & ~ep;
      e1 = ev & ep;
      n_cmp++;
      if (rvalid0_w[k] !== e0) begin
        n_err++;
        $display("FAIL rvalid0 L=%0d cyc=%0d got %b exp %b", k + 1, cyc, rvalid0_w[k], e0);
      end
      n_cmp++;
      if (rvalid1_w[k] !== e1) begin
        n_err++;
        $display("FAIL rvalid1 L=%0d cyc=%0d got %b exp %b", k + 1, cyc, rvalid1_w[k], e1);
      end
      if (e0) begin
        n_cmp++;
        if (rdata0_w[k] !== ed) begin
          n_err++;
          $display("FAIL rdata0 L=%0d cyc=%0d got %h exp %h", k + 1, cyc, rdata0_w[k], ed);
        end
      end
      if (e1) begin
        n_cmp++;
        if (rdata1_w[k] !== ed) begin
          n_err++;
          $display("FAIL rdata1 L=%0d cyc=%0d got %h exp %h", k + 1, cyc, rdata1_w[k], ed);
        end
      end
    end
    while (sb.size() > 0 && sb[0].acc <= cyc - N) void'(sb.pop_front());
  end

  // Drive one cycle from posedge+1. Check the grant and the RAM drive against
  // the model, record accepted reads, and return at the next posedge+1.
  task automatic apply_cycle(input logic r0, input logic w0, input logic [AW-1:0] a0,
                             input logic [DW-1:0] d0, input logic r1, input logic w1,
                             input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                             output logic [1:0] g_obs);
    logic eg0, eg1, ewen;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #2;
    eg0 = 1'b0; eg1 = 1'b0;
    if (resetn) begin
      if (r0 && r1) begin eg0 = m_last; eg1 = ~m_last; end
      else begin eg0 = r0; eg1 = r1; end
    end
    ewen = eg0 ? w0 : (eg1 ? w1 : 1'b0);
    ea   = eg0 ? a0 : (eg1 ? a1 : '0);
    ed   = eg0 ? d0 : (eg1 ? d1 : '0);
    g_obs = {gnt1_w[0], gnt0_w[0]};
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if ({gnt1_w[k], gnt0_w[k]} !== {eg1, eg0}) begin
        n_err++;
        $display("FAIL gnt L=%0d cyc=%0d got %b%b exp %b%b", k + 1, cyc, gnt1_w[k], gnt0_w[k], eg1, eg0);
      end
      n_cmp++;
      if ({ram_wen_w[k], ram_addr_w[k], ram_data_w[k]} !== {ewen, ea, ed}) begin
        n_err++;
        $display("FAIL ram_drive L=%0d cyc=%0d got %b/%h/%h exp %b/%h/%h", k + 1, cyc,
                 ram_wen_w[k], ram_addr_w[k], ram_data_w[k], ewen, ea, ed);
      end
    end
    if (eg0 || eg1) begin
      if (ewen) m_mem[ea] = ed;
      else sb.push_back('{acc: cyc, port: eg1, data: m_mem[ea]});
      m_last = eg1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [1:0] g;
    for (int i = 0; i < n; i++) apply_cycle(0, 0, '0, '0, 0, 0, '0, '0, g);
  endtask

  task automatic do_reset();
    logic [1:0] g;
    resetn = 1'b0;
    sb.delete();
    m_last = 1'b1;
    apply_cycle(1, 0, 8'h10, '0, 1, 0, 8'h20, '0, g);
    apply_cycle(1, 0, 8'h10, '0, 1, 0, 8'h20, '0, g);
    resetn = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    n_cmp++;
    if ({gnt0_w, gnt1_w, ram_wen_w, rvalid0_w, rvalid1_w} !== '0) begin
      n_err++;
      $display("FAIL %s got gnt0=%b gnt1=%b wen=%b rv0=%b rv1=%b exp all 0", tag,
               gnt0_w, gnt1_w, ram_wen_w, rvalid0_w, rvalid1_w);
    end
  endtask

  task automatic test_reset();
    logic [1:0] g;
    @(posedge clk); #1;
    apply_cycle(1, 1, 8'h33, 32'h1, 1, 1, 8'h44, 32'h2, g);
    apply_cycle(1, 1, 8'h33, 32'h1, 1, 1, 8'h44, 32'h2, g);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      #1 check_quiet("reset_idle");
    end
  endtask

  task automatic test_write_readback();
    logic [1:0] g;
    apply_cycle(1, 1, 8'h01, 32'hAABBCCDD, 0, 0, '0, '0, g);
    n_cmp++;
    if (g !== 2'b01) begin n_err++; $display("FAIL wr_gnt got %b exp 01", g); end
    apply_cycle(1, 0, 8'h01, '0, 0, 0, '0, '0, g);
    for (int lat = 1; lat <= N; lat++) begin
      #1;
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (rvalid0_w[k] !== (k == lat - 1) || rvalid1_w[k] !== 1'b0) begin
          n_err++;
          $display("FAIL rb_latency L=%0d t=%0d got rv0=%b rv1=%b exp rv0=%b rv1=0",
                   k + 1, lat, rvalid0_w[k], rvalid1_w[k], k == lat - 1);
        end
      end
      n_cmp++;
      if (rdata0_w[lat-1] !== 32'hAABBCCDD) begin
        n_err++;
        $display("FAIL rb_data L=%0d got %h exp aabbccdd", lat, rdata0_w[lat-1]);
      end
      idle(1);
    end
    idle(2);
  endtask

  task automatic test_conflict();
    logic [1:0] g;
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    apply_cycle(1, 0, 8'h30, '0, 0, 0, '0, '0, g);  // last winner becomes port 0
    idle(3);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply_cycle(1, 0, 8'h10, '0, 1, 0, 8'h20, '0, g);
      n_cmp++;
      if (g !== exp_g[i]) begin
        n_err++;
        $display("FAIL rr_gnt step=%0d got %b exp %b", i, g, exp_g[i]);
      end
    end
    idle(4);
  endtask

  task automatic test_mixed();
    logic [1:0] g;
    apply_cycle(1, 0, 8'h40, '0, 0, 0, '0, '0, g);  // last winner becomes port 0
    apply_cycle(1, 0, 8'h05, '0, 1, 1, 8'h05, 32'h12345678, g);
    n_cmp++;
    if (g !== 2'b10) begin n_err++; $display("FAIL mixed_gnt got %b exp 10", g); end
    apply_cycle(1, 0, 8'h05, '0, 0, 0, '0, '0, g);
    n_cmp++;
    if (g !== 2'b01) begin n_err++; $display("FAIL mixed_retry got %b exp 01", g); end
    #1;
    n_cmp++;
    if (rvalid0_w[0] !== 1'b1 || rdata0_w[0] !== 32'h12345678) begin
      n_err++;
      $display("FAIL mixed_data got rv0=%b %h exp 1 12345678", rvalid0_w[0], rdata0_w[0]);
    end
    idle(4);
  endtask

  task automatic test_reset_midflight();
    logic [1:0] g;
    apply_cycle(0, 0, '0, '0, 1, 0, 8'h20, '0, g);
    n_cmp++;
    if (g !== 2'b10) begin n_err++; $display("FAIL mf_gnt got %b exp 10", g); end
    #6;                       // just past the negedge of the following cycle
    resetn = 1'b0;
    sb.delete();
    m_last = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    #1 check_quiet("mf_in_reset");
    @(posedge clk); #1;
    apply_cycle(1, 0, 8'h10, '0, 1, 0, 8'h20, '0, g);
    apply_cycle(1, 0, 8'h10, '0, 1, 0, 8'h20, '0, g);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      #1;
      n_cmp++;
      if (rvalid1_w !== '0) begin
        n_err++;
        $display("FAIL mf_no_rvalid1 got %b exp 000", rvalid1_w);
      end
    end
    apply_cycle(1, 0, 8'h10, '0, 1, 0, 8'h20, '0, g);
    n_cmp++;
    if (g !== 2'b01) begin n_err++; $display("FAIL mf_first_conflict got %b exp 01", g); end
    idle(4);
  endtask

  initial begin
    resetn = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    m_last = 1'b1;
    for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
    test_reset();
    test_write_readback();
    test_conflict();
    test_mixed();
    test_reset_midflight();
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu4_ram_arbiter.md
Name: cpu4_ram_arbiter

Overview:
Two-port round-robin arbiter that shares the single-port cpu4_ram (8-bit word address, 32-bit data, synchronous write, registered read) between two requesters. Requester 0 is instruction fetch and requester 1 is load/store.
- At most one access is issued to the RAM per clock.
- Read-return ownership is tracked through a latency pipeline, so each read response is routed back to the requester that issued it.

Parameters:
AW, 8, RAM word-address width
DW, 32, RAM data width
RD_LATENCY, 1, clocks from the accepting edge until ram_q holds read data (1..4)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
req0  input  1  requester 0 access request
we0  input  1  requester 0 write (1) / read (0)
addr0  input  AW  requester 0 address
wdata0  input  DW  requester 0 write data
gnt0  output  1  requester 0 granted this cycle
rvalid0  output  1  read data valid for requester 0
rdata0  output  DW  read data for requester 0
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for requester 1
ram_address  output  AW  to RAM address
ram_data  output  DW  to RAM data
ram_wen  output  1  to RAM write enable
ram_q  input  DW  from RAM read data

Behaviour:
- Grant is combinational in the same cycle as the request. A request is accepted on the rising edge where reqN=1 and gntN=1.
- The requester must hold req/we/addr/wdata stable until it is granted. Dropping req before grant is allowed; the request is then simply lost.
- Single requester: that requester is granted. No requesters: gnt0=gnt1=0.
- Both requesting: grant goes to the port that is not in last_gnt.
  - last_gnt is a 1-bit register, reset to 1, so port 0 wins the first conflict.
  - last_gnt updates on every accepted access to the granted port index.
- RAM drive:
  - ram_address, ram_data and ram_wen come from the granted port; ram_wen = weN of that port.
  - With no grant: ram_wen=0, ram_address=0, ram_data=0.
- Read-return pipeline:
  - Shift register of RD_LATENCY stages, each holding {valid, owner}.
  - On an accepted read, stage 0 loads {1, port}; on writes or idle cycles it loads {0, x}.
  - When the last stage is valid, rvalid of its owner is 1 for exactly one cycle.
  - rdata0 and rdata1 are both driven by ram_q, combinationally. They are meaningful only while the matching rvalid is 1.
- Throughput:
  - One access per clock; back-to-back reads from either port are fully pipelined.
  - rvalid order equals acceptance order.
  - A write accepted in cycle N followed by a read of the same address in cycle N+1 returns the new data (RAM write-first at the edge).
- Reset (resetn=0, asynchronous):
  - Pipeline valid bits clear and last_gnt=1.
  - gnt0, gnt1, ram_wen, rvalid0, rvalid1 are all forced to 0 while resetn is low.
  - Reads in flight when reset asserts are discarded and never produce rvalid.
- Simultaneous events:
  - An rvalid to port X in the same cycle as a new grant to port X is legal; the two are independent.
  - A write never produces rvalid.

Test Plan:
- Reset then idle: resetn low 2 clk, then high with no req -> gnt0=gnt1=0, ram_wen=0, rvalid0=rvalid1=0 for 5 clk.
- Write/readback, port 0:
  - req0 we0=1 addr0=8'h01 wdata0=32'hAABBCCDD -> gnt0 same cycle, ram_wen=1, ram_address=8'h01.
  - Next clk, req0 read addr 8'h01 -> rvalid0=1 exactly RD_LATENCY clk after acceptance, rdata0=32'hAABBCCDD, rvalid1=0.
- Conflict round-robin:
  - Both ports read continuously, port 0 at addr 8'h10, port 1 at addr 8'h20, after reset -> grants alternate 0,1,0,1.
  - rvalid pulses alternate 0,1,0,1 with rdata matching the preloaded contents of 8'h10 and 8'h20.
- Mixed access: port 1 writes 32'h12345678 to 8'h05 while port 0 reads 8'h05 in the same cycle, with last_gnt=0 -> port 1 wins; port 0's read is accepted the next cycle and returns 32'h12345678.
- Reset mid-flight: with RD_LATENCY=2, accept a port 1 read, then assert resetn low one clk later -> no rvalid1 ever appears; the first conflict after release grants port 0.
- Latency sweep: repeat the write/readback scenario with RD_LATENCY=1 and RD_LATENCY=3 -> rvalid delay equals the parameter, and each response is a single-cycle pulse.
